// File: rtl/uart_sample_framer_if.sv
// Sample-in and transmitter byte handshake bundle for uart_sample_framer.
// The master side is the framer, which drives the byte-valid strobe toward the UART.
interface uart_sample_framer_if;
    logic        i_Sample_DV;
    logic [15:0] i_Sample;
    logic        i_Tx_Active;
    logic        i_Tx_Done;
    logic        o_Tx_DV;
    logic [7:0]  o_Tx_Byte;

    modport master (
        input  i_Sample_DV, i_Sample, i_Tx_Active, i_Tx_Done,
        output o_Tx_DV, o_Tx_Byte
    );

    modport slave (
        output i_Sample_DV, i_Sample, i_Tx_Active, i_Tx_Done,
        input  o_Tx_DV, o_Tx_Byte
    );
endinterface

// File: rtl/uart_sample_framer.sv
// Buffers 16-bit samples in a small FIFO and serialises each one into a
// sync/high/low/checksum frame, paced by the UART transmitter's active/done.
module uart_sample_framer #(
    parameter int unsigned FIFO_AW   = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                 osc_clk,
    input  logic                 i_Rst_n,
    uart_sample_framer_if.master bus,
    output logic                 o_Busy,
    output logic [FIFO_AW:0]     o_Fifo_Level,
    output logic                 o_Overflow,
    output logic [7:0]           o_Drop_Count
);
    localparam int unsigned        DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_ACT, WAIT_DONE, WAIT_REL} state_t;

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [15:0]        word_q, word_d;
    logic               tx_dv_d, busy_d;
    logic [7:0]         tx_byte_d;

    logic [15:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic               full, pop, push, drop;

    function automatic logic [7:0] frame_byte(input logic [15:0] w, input logic [1:0] i);
        case (i)
            2'd0:    return SYNC_BYTE;
            2'd1:    return w[15:8];
            2'd2:    return w[7:0];
            default: return w[15:8] ^ w[7:0];
        endcase
    endfunction

    // A pop in the same cycle frees a slot, so a strobe into a full FIFO is still accepted.
    assign full = (o_Fifo_Level == LVL_FULL);
    assign pop  = (state_q == IDLE) && (o_Fifo_Level != '0);
    assign push = bus.i_Sample_DV && (!full || pop);
    assign drop = bus.i_Sample_DV && full && !pop;

    // NOTE: the sample storage has no reset; clearing the pointers and level
    // makes any stale contents unreachable, and a reset-free array maps to RAM.
    always_ff @(posedge osc_clk) begin
        if (push) mem[wr_ptr_q] <= bus.i_Sample;
    end

    // NOTE: sequential state is written with <= so every update in the block
    // sees pre-edge values regardless of statement order.
    always_ff @(posedge osc_clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            o_Fifo_Level <= '0;
            o_Overflow   <= 1'b0;
            o_Drop_Count <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (push && !pop)      o_Fifo_Level <= o_Fifo_Level + LVL_ONE;
            else if (pop && !push) o_Fifo_Level <= o_Fifo_Level - LVL_ONE;
            if (drop) begin
                o_Overflow <= 1'b1;
                if (o_Drop_Count != 8'hFF) o_Drop_Count <= o_Drop_Count + 8'd1;
            end
        end
    end

    always_ff @(posedge osc_clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            word_q        <= '0;
            bus.o_Tx_DV   <= 1'b0;
            bus.o_Tx_Byte <= '0;
            o_Busy        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            word_q        <= word_d;
            bus.o_Tx_DV   <= tx_dv_d;
            bus.o_Tx_Byte <= tx_byte_d;
            o_Busy        <= busy_d;
        end
    end

    // NOTE: each combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    word_d  = mem[rd_ptr_q];
                    idx_d   = 2'd0;
                    state_d = SEND;
                end
            end
            SEND:      state_d = WAIT_ACT;
            WAIT_ACT:  if (bus.i_Tx_Active) state_d = WAIT_DONE;
            WAIT_DONE: if (bus.i_Tx_Done)   state_d = WAIT_REL;
            WAIT_REL: begin
                if (!bus.i_Tx_Done) begin
                    if (idx_q != 2'd3) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they are glitch-free.
    always_comb begin
        tx_dv_d   = (state_d == SEND);
        busy_d    = (state_d != IDLE);
        tx_byte_d = bus.o_Tx_Byte;
        if (state_d == SEND) tx_byte_d = frame_byte(word_d, idx_d);
    end
endmodule

// File: tb/tb_uart_sample_framer.sv
// Self-checking bench for uart_sample_framer: a behavioural transmitter,
// a byte scoreboard, a vector table and hand-written corner sequences.
module tb_uart_sample_framer;
    localparam int FIFO_AW = 4;

    logic               osc_clk = 1'b0;
    logic               rst_n;
    logic               busy;
    logic [FIFO_AW:0]   level;
    logic               ovf;
    logic [7:0]         drops;

    uart_sample_framer_if bus();

    uart_sample_framer #(.FIFO_AW(FIFO_AW), .SYNC_BYTE(8'hA5)) dut (
        .osc_clk      (osc_clk),
        .i_Rst_n      (rst_n),
        .bus          (bus),
        .o_Busy       (busy),
        .o_Fifo_Level (level),
        .o_Overflow   (ovf),
        .o_Drop_Count (drops)
    );

    always #5 osc_clk = ~osc_clk;

    typedef struct packed {
        logic [15:0] sample;
        logic [31:0] frame;
    } vec_t;

    vec_t        vecs [6];
    logic [7:0]  exp_q [$];
    int          n_pass = 0;
    int          n_total = 0;

    int          act_delay = 1;
    int          busy_len = 40;
    int          done_len = 1;
    logic        stall = 1'b0;
    int          phase = 0;
    int          cnt = 0;
    logic        pending = 1'b0;
    logic        prev_dv = 1'b0;
    int          dv_count = 0;
    int          peak = 0;

    task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, act === exp, act, exp);
    endtask

    function automatic logic [31:0] frame_of(input logic [15:0] s);
        return {8'hA5, s[15:8], s[7:0], s[15:8] ^ s[7:0]};
    endfunction

    task automatic push_frame(input logic [31:0] f);
        exp_q.push_back(f[31:24]);
        exp_q.push_back(f[23:16]);
        exp_q.push_back(f[15:8]);
        exp_q.push_back(f[7:0]);
    endtask

    task automatic strobe(input logic [15:0] s);
        @(negedge osc_clk);
        bus.i_Sample_DV = 1'b1;
        bus.i_Sample    = s;
        @(negedge osc_clk);
        bus.i_Sample_DV = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge osc_clk);
            if (int'(level) > peak) peak = int'(level);
            n++;
        end while ((busy || exp_q.size() != 0 || phase != 0 || level != '0) && n < budget);
        check(name, n < budget, 32'(n), 32'(budget));
    endtask

    // Transmitter model plus protocol monitor and scoreboard, all on the falling edge.
    initial begin
        bus.i_Tx_Active = 1'b0;
        bus.i_Tx_Done   = 1'b0;
        forever begin
            @(negedge osc_clk);
            if (!rst_n) begin
                phase = 0;
                pending = 1'b0;
                prev_dv = 1'b0;
                bus.i_Tx_Active = 1'b0;
                bus.i_Tx_Done   = 1'b0;
                exp_q.delete();
            end else begin
                if (bus.o_Tx_DV) begin
                    dv_count++;
                    check("dv_back_to_back", !prev_dv, 32'(prev_dv), 32'd0);
                    check("dv_while_tx_busy", !(bus.i_Tx_Active || bus.i_Tx_Done),
                          32'({bus.i_Tx_Active, bus.i_Tx_Done}), 32'd0);
                    check("scoreboard_nonempty", exp_q.size() != 0, 32'(exp_q.size()), 32'd1);
                    if (exp_q.size() != 0) check_eq("tx_byte", 32'(bus.o_Tx_Byte), 32'(exp_q.pop_front()));
                end
                prev_dv = bus.o_Tx_DV;
                if (bus.o_Tx_DV) pending = 1'b1;
                case (phase)
                    0: if (pending && !stall) begin pending = 1'b0; cnt = act_delay; phase = 1; end
                    1: if (cnt <= 1) begin bus.i_Tx_Active = 1'b1; cnt = busy_len; phase = 2; end else cnt--;
                    2: if (cnt <= 1) begin bus.i_Tx_Active = 1'b0; bus.i_Tx_Done = 1'b1; cnt = done_len; phase = 3; end
                       else cnt--;
                    default: if (cnt <= 1) begin bus.i_Tx_Done = 1'b0; phase = 0; end else cnt--;
                endcase
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dv0;
        int n;
        rst_n = 1'b0;
        bus.i_Sample_DV = 1'b0;
        bus.i_Sample    = '0;
        vecs[0] = '{16'h1234, 32'hA5123426};
        vecs[1] = '{16'h0001, 32'hA5000101};
        vecs[2] = '{16'hFFFF, 32'hA5FFFF00};
        vecs[3] = '{16'h8000, 32'hA5800080};
        vecs[4] = '{16'hAA55, 32'hA5AA55FF};
        vecs[5] = '{16'h5A3C, 32'hA55A3C66};

        repeat (3) @(negedge osc_clk);
        check_eq("rst_tx_dv", 32'(bus.o_Tx_DV), 32'd0);
        check_eq("rst_tx_byte", 32'(bus.o_Tx_Byte), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_overflow", 32'(ovf), 32'd0);
        check_eq("rst_drops", 32'(drops), 32'd0);
        rst_n = 1'b1;

        // Push-to-first-byte latency.
        push_frame(frame_of(16'h4321));
        strobe(16'h4321);
        check_eq("lat_level_t1", 32'(level), 32'd1);
        check_eq("lat_dv_t1", 32'(bus.o_Tx_DV), 32'd0);
        check_eq("lat_busy_t1", 32'(busy), 32'd0);
        @(negedge osc_clk);
        check_eq("lat_dv_t2", 32'(bus.o_Tx_DV), 32'd1);
        check_eq("lat_byte_t2", 32'(bus.o_Tx_Byte), 32'hA5);
        check_eq("lat_busy_t2", 32'(busy), 32'd1);
        check_eq("lat_level_t2", 32'(level), 32'd0);
        wait_idle("lat_drain", 2000);

        for (int i = 0; i < 6; i++) begin
            dv0 = dv_count;
            push_frame(vecs[i].frame);
            strobe(vecs[i].sample);
            wait_idle($sformatf("vec%0d_drain", i), 2000);
            check_eq($sformatf("vec%0d_dv_pulses", i), 32'(dv_count - dv0), 32'd4);
            check_eq($sformatf("vec%0d_busy_after", i), 32'(busy), 32'd0);
        end

        // Three strobes on consecutive cycles.
        peak = 0;
        push_frame(32'hA5000101);
        push_frame(32'hA5FFFF00);
        push_frame(32'hA5800080);
        @(negedge osc_clk); bus.i_Sample_DV = 1'b1; bus.i_Sample = 16'h0001;
        @(negedge osc_clk); bus.i_Sample = 16'hFFFF;
        @(negedge osc_clk); bus.i_Sample = 16'h8000;
        @(negedge osc_clk); bus.i_Sample_DV = 1'b0;
        wait_idle("three_drain", 4000);
        check_eq("three_peak_level", 32'(peak), 32'd2);

        // Burst of 19 strobes with the transmitter stalled mid-frame.
        stall = 1'b1;
        for (int i = 0; i < 19; i++) begin
            @(negedge osc_clk);
            bus.i_Sample_DV = 1'b1;
            bus.i_Sample    = 16'h1000 + 16'(i);
            if (i < 17) push_frame(frame_of(16'h1000 + 16'(i)));
        end
        @(negedge osc_clk); bus.i_Sample_DV = 1'b0;
        check_eq("burst_overflow", 32'(ovf), 32'd1);
        check_eq("burst_drops", 32'(drops), 32'd2);
        check_eq("burst_level", 32'(level), 32'd16);

        // Strobe exactly in the pop cycle of a full FIFO.
        stall = 1'b0;
        n = 0;
        do begin @(negedge osc_clk); n++; end while (busy && n < 2000);
        check("pop_cycle_reached", n < 2000, 32'(n), 32'd2000);
        bus.i_Sample_DV = 1'b1;
        bus.i_Sample    = 16'hBEEF;
        push_frame(frame_of(16'hBEEF));
        @(negedge osc_clk); bus.i_Sample_DV = 1'b0;
        stall = 1'b1;
        check_eq("coincide_level", 32'(level), 32'd16);
        check_eq("coincide_drops", 32'(drops), 32'd2);

        for (int i = 0; i < 300; i++) begin
            @(negedge osc_clk);
            bus.i_Sample_DV = 1'b1;
            bus.i_Sample    = 16'hDEAD;
        end
        @(negedge osc_clk); bus.i_Sample_DV = 1'b0;
        check_eq("sat_drops", 32'(drops), 32'd255);
        check_eq("sat_overflow", 32'(ovf), 32'd1);
        check_eq("sat_level", 32'(level), 32'd16);
        stall = 1'b0;
        wait_idle("burst_drain", 20000);

        // Reset during byte 2 of a frame, with more samples queued behind it.
        dv0 = dv_count;
        push_frame(32'hA5123426);
        strobe(16'h1234);
        n = 0;
        while (dv_count < dv0 + 3 && n < 2000) begin @(negedge osc_clk); n++; end
        check("rst_reach_byte2", n < 2000, 32'(n), 32'd2000);
        strobe(16'h1111);
        strobe(16'h2222);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_tx_dv", 32'(bus.o_Tx_DV), 32'd0);
        check_eq("midrst_tx_byte", 32'(bus.o_Tx_Byte), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_level", 32'(level), 32'd0);
        check_eq("midrst_overflow", 32'(ovf), 32'd0);
        check_eq("midrst_drops", 32'(drops), 32'd0);
        repeat (2) @(negedge osc_clk);
        rst_n = 1'b1;
        dv0 = dv_count;
        push_frame(32'hA55A3C66);
        strobe(16'h5A3C);
        wait_idle("postrst_drain", 2000);
        check_eq("postrst_dv_pulses", 32'(dv_count - dv0), 32'd4);

        // Slow transmitter: late active, done held for five cycles.
        act_delay = 3;
        done_len  = 5;
        dv0 = dv_count;
        push_frame(32'hA5C3A566);
        push_frame(32'hA50F0F00);
        strobe(16'hC3A5);
        strobe(16'h0F0F);
        wait_idle("slow_drain", 4000);
        check_eq("slow_dv_pulses", 32'(dv_count - dv0), 32'd8);
        check_eq("slow_busy_after", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
